// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state and owner encodings for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} arb_state_t;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_MEM = 1'b1;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of consecutive MEM grants made while IF waits
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] MAX = W'(LIMIT);
    logic [W-1:0] streak;
    always_ff @(posedge clk) begin
        if (reset || clr) streak <= '0;
        else if (inc && streak != MAX) streak <= streak + 1'b1;
    end
    assign at_limit = streak == MAX;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and MEM, one transaction
// outstanding, MEM priority with a starvation bound for IF.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                flush_IF,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    output logic                stall_IF,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_done,
    output logic                stall_MEM,
    output logic                bus_req,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ack,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata
);
    arb_state_t state;
    logic owner, discard, at_limit, pick, grant_if, flush_hit;
    assign pick = state == IDLE && (if_req || mem_req);
    assign grant_if = if_req && (!mem_req || at_limit);
    assign flush_hit = flush_IF && owner == OWN_IF;
    arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_streak (
        .clk      (clk),
        .reset    (reset),
        .inc      (pick && !grant_if && if_req),
        .clr      (pick && (grant_if || !if_req)),
        .at_limit (at_limit)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= OWN_IF;
            discard <= 1'b0;
            bus_we <= 1'b0;
            bus_wstrb <= '0;
            bus_addr <= '0;
            bus_wdata <= '0;
            if_rdata <= '0;
            mem_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (pick) begin
                    state <= REQ;
                    owner <= grant_if ? OWN_IF : OWN_MEM;
                    bus_addr <= grant_if ? if_addr : mem_addr;
                    bus_we <= !grant_if && mem_we;
                    bus_wstrb <= grant_if ? '0 : mem_wstrb;
                    bus_wdata <= grant_if ? '0 : mem_wdata;
                end
                REQ: begin
                    if (bus_ack) state <= RESP;
                    if (flush_hit) discard <= 1'b1;
                end
                RESP: begin
                    if (flush_hit) discard <= 1'b1;
                    // a cancelled fetch still waits for its response, but the word is dropped
                    if (bus_rvalid) begin
                        state <= DONE;
                        if (owner == OWN_MEM) mem_rdata <= bus_rdata;
                        else if (!discard && !flush_IF) if_rdata <= bus_rdata;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    discard <= 1'b0;
                end
            endcase
        end
    end
    assign bus_req = !reset && state == REQ;
    assign mem_done = !reset && state == DONE && owner == OWN_MEM;
    assign if_done = !reset && state == DONE && owner == OWN_IF && !discard && !flush_IF;
    assign stall_IF = !reset && if_req && !if_done;
    assign stall_MEM = !reset && mem_req && !mem_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tests with a transaction-level model checked every cycle
module tb_mem_port_arbiter;
    localparam int AW = 32, DW = 32, SL = 2;
    logic clk = 0, reset = 1;
    logic if_req = 0, flush_IF = 0, mem_req = 0, mem_we = 0;
    logic [AW-1:0] if_addr = '0, mem_addr = '0;
    logic [DW/8-1:0] mem_wstrb = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic bus_ack = 0, bus_rvalid = 0;
    logic [DW-1:0] bus_rdata = '0;
    logic [DW-1:0] if_rdata, mem_rdata, bus_wdata;
    logic if_done, mem_done, stall_IF, stall_MEM, bus_req, bus_we;
    logic [DW/8-1:0] bus_wstrb;
    logic [AW-1:0] bus_addr;
    int checks = 0, errors = 0;
    bit run = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .flush_IF(flush_IF),
        .if_rdata(if_rdata), .if_done(if_done), .stall_IF(stall_IF),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_MEM(stall_MEM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // which: 0 if_done, 1 mem_done, 2 bus_ack, 3 bus_req
    task automatic wait_sig(input int which, input string nm);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            case (which)
                0: seen = if_done;
                1: seen = mem_done;
                2: seen = bus_ack;
                default: seen = bus_req;
            endcase
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: timed out after 40 cycles", nm);
        end
    endtask

    // memory: ack after ack_wait cycles of bus_req, response rv_wait cycles after ack
    int ack_wait = 0, rv_wait = 0, mcnt = 0;
    bit mph = 0;
    logic [DW-1:0] rd_val = '0;
    always @(posedge clk) begin
        #2;
        bus_ack = 0;
        bus_rvalid = 0;
        if (reset) begin
            mph = 0;
            mcnt = 0;
        end else if (!mph) begin
            if (bus_req) begin
                if (mcnt >= ack_wait) begin bus_ack = 1; mph = 1; mcnt = 0; end
                else mcnt++;
            end
        end else if (mcnt >= rv_wait) begin
            bus_rvalid = 1;
            bus_rdata = rd_val ^ bus_addr;
            mph = 0;
            mcnt = 0;
        end else mcnt++;
    end

    // transaction model: one access in flight, tracked as granted / accepted / completed
    bit m_busy = 0, m_acked = 0, m_done = 0, m_own_mem = 0, m_cancel = 0;
    int m_streak = 0;
    logic [AW-1:0] m_addr = '0;
    logic m_we = 0;
    logic [DW/8-1:0] m_wstrb = '0;
    logic [DW-1:0] m_wdata = '0, m_if_data = '0, m_mem_data = '0;
    bit grants[$];
    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_acked = 0; m_done = 0; m_cancel = 0; m_streak = 0;
            m_if_data = '0; m_mem_data = '0;
        end else if (m_done) begin
            m_busy = 0; m_done = 0; m_cancel = 0;
        end else if (!m_busy) begin
            if (if_req || mem_req) begin
                m_own_mem = mem_req && !(if_req && m_streak == SL);
                m_streak = (m_own_mem && if_req) ? (m_streak < SL ? m_streak + 1 : SL) : 0;
                m_addr = m_own_mem ? mem_addr : if_addr;
                m_we = m_own_mem && mem_we;
                m_wstrb = mem_wstrb;
                m_wdata = mem_wdata;
                grants.push_back(m_own_mem);
                m_busy = 1;
                m_acked = 0;
            end
        end else begin
            if (flush_IF && !m_own_mem) m_cancel = 1;
            if (!m_acked) m_acked = bus_ack;
            else if (bus_rvalid) begin
                m_done = 1;
                if (m_own_mem) m_mem_data = bus_rdata;
                else if (!m_cancel) m_if_data = bus_rdata;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin : cmp
            logic e_req, e_ifd, e_memd;
            e_req = !reset && m_busy && !m_acked;
            e_ifd = !reset && m_done && !m_own_mem && !m_cancel && !flush_IF;
            e_memd = !reset && m_done && m_own_mem;
            chkb("bus_req", bus_req, e_req);
            chkb("if_done", if_done, e_ifd);
            chkb("mem_done", mem_done, e_memd);
            chkb("stall_IF", stall_IF, !reset && if_req && !e_ifd);
            chkb("stall_MEM", stall_MEM, !reset && mem_req && !e_memd);
            chk("if_rdata", if_rdata, m_if_data);
            chk("mem_rdata", mem_rdata, m_mem_data);
            if (e_req) begin
                chk("bus_addr", bus_addr, m_addr);
                chkb("bus_we", bus_we, m_we);
                if (m_own_mem) begin
                    chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, m_wstrb});
                    chk("bus_wdata", bus_wdata, m_wdata);
                end
            end
        end
    end

    initial begin
        step();
        run = 1;
        step();
        reset = 0;
        step();
        // IF-only read
        rd_val = 32'hDEADBFEF;
        if_req = 1; if_addr = 32'h100;
        @(negedge clk); chkb("t1_stall_c0", stall_IF, 1); chkb("t1_req_c0", bus_req, 0);
        @(negedge clk); chkb("t1_req_c1", bus_req, 1); chk("t1_addr", bus_addr, 32'h100);
        @(negedge clk); chkb("t1_stall_c2", stall_IF, 1);
        @(negedge clk); chkb("t1_done_c3", if_done, 1); chk("t1_rdata", if_rdata, 32'hDEADBEEF);
        step(); if_req = 0;
        // store with a fetch waiting
        rd_val = 32'h0BAD0000;
        mem_req = 1; mem_we = 1; mem_wstrb = 4'b0011; mem_addr = 32'h2004; mem_wdata = 32'h12345678;
        if_req = 1; if_addr = 32'h300;
        @(negedge clk); @(negedge clk);
        chkb("st_we", bus_we, 1); chk("st_addr", bus_addr, 32'h2004);
        chk("st_wstrb", {28'b0, bus_wstrb}, 32'h3); chk("st_wdata", bus_wdata, 32'h12345678);
        wait_sig(1, "st_done"); chkb("st_no_ifdone", if_done, 0);
        step(); mem_req = 0; mem_we = 0;
        wait_sig(0, "st_if_after"); chk("st_if_addr", bus_addr, 32'h300);
        step(); if_req = 0;
        // starvation bound: both held and re-raised
        grants.delete();
        rd_val = 32'h55550000;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    mem_addr = 32'h3000 + 4 * k; mem_req = 1;
                    wait_sig(1, "go_mem"); step();
                end
                mem_req = 0;
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    if_addr = 32'h1000 + 4 * k; if_req = 1;
                    wait_sig(0, "go_if"); step();
                end
                if_req = 0;
            end
        join
        chk("go_count", grants.size(), 6);
        for (int k = 0; k < 6 && k < grants.size(); k++)
            chkb($sformatf("go_order_%0d", k), grants[k], (k % 3) != 2);
        // flush in RESP
        rv_wait = 3; rd_val = 32'hCAFE0000;
        if_req = 1; if_addr = 32'h180;
        wait_sig(2, "fl_ack");
        step(); flush_IF = 1; if_addr = 32'h200;
        step(); flush_IF = 0;
        wait_sig(0, "fl_done"); chk("fl_addr", bus_addr, 32'h200); chk("fl_rdata", if_rdata, 32'hCAFE0200);
        step(); if_req = 0; rv_wait = 0;
        // slow ack with flush while in REQ
        ack_wait = 5; rd_val = 32'h77000000;
        if_req = 1; if_addr = 32'h400;
        wait_sig(3, "sa_req"); chk("sa_addr_c1", bus_addr, 32'h400);
        step(); flush_IF = 1; if_addr = 32'h404;
        step(); flush_IF = 0;
        @(negedge clk); chkb("sa_req_held", bus_req, 1); chk("sa_addr_held", bus_addr, 32'h400);
        wait_sig(0, "sa_done"); chk("sa_addr", bus_addr, 32'h404); chk("sa_rdata", if_rdata, 32'h77000404);
        step(); if_req = 0; ack_wait = 0;
        // reset in RESP with the streak at its limit
        rv_wait = 2; rd_val = 32'h66000000;
        if_req = 1; if_addr = 32'h500; mem_req = 1; mem_addr = 32'h600;
        wait_sig(1, "rs_m1"); step(); mem_addr = 32'h604;
        wait_sig(2, "rs_ack"); step(); reset = 1;
        @(negedge clk);
        chkb("rs_req", bus_req, 0); chkb("rs_stall_if", stall_IF, 0); chkb("rs_stall_mem", stall_MEM, 0);
        step();
        @(negedge clk);
        chk("rs_addr", bus_addr, 0); chk("rs_ifr", if_rdata, 0); chk("rs_memr", mem_rdata, 0);
        chkb("rs_mdone", mem_done, 0); chkb("rs_we", bus_we, 0);
        step(); reset = 0;
        wait_sig(3, "rs_regrant"); chk("rs_streak_clear", bus_addr, 32'h604);
        wait_sig(1, "rs_mdone2"); chk("rs_memr2", mem_rdata, 32'h66000604);
        step(); mem_req = 0;
        wait_sig(0, "rs_idone"); chk("rs_if_rdata", if_rdata, 32'h66000500);
        step(); if_req = 0;
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the core's single memory port between instruction fetch (IF) and the data-memory stage (MEM) of the 5-stage pipeline.
- Serialises accesses with one transaction outstanding at a time.
- Drives the per-requester stall signals consumed by the pipeline registers and the hazard unit.
- Discards an in-flight fetch when a taken branch flushes IF.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, max consecutive MEM grants while if_req pending (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_done
- if_addr  in  ADDR_W  fetch address
- flush_IF  in  1  taken branch; cancels the current fetch
- if_rdata  out  DATA_W  fetched word, valid with if_done
- if_done  out  1  one-cycle completion pulse
- stall_IF  out  1  if_req && !if_done
- mem_req  in  1  data request; held with operands until mem_done
- mem_we  in  1  1 = store
- mem_wstrb  in  DATA_W/8  byte enables for stores
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, valid with mem_done
- mem_done  out  1  one-cycle completion pulse
- stall_MEM  out  1  mem_req && !mem_done
- bus_req  out  1  memory request; held until bus_ack
- bus_we, bus_wstrb, bus_addr, bus_wdata  out  1 / DATA_W/8 / ADDR_W / DATA_W  registered request fields
- bus_ack  in  1  memory accepted the request this cycle
- bus_rvalid  in  1  response/completion for both reads and writes
- bus_rdata  in  DATA_W  read data

## Operation
States:
- IDLE
  - Samples requests.
  - If any request is pending: latch owner and request fields, go to REQ.
- REQ
  - bus_req=1.
  - On bus_ack, go to RESP.
- RESP
  - On bus_rvalid: capture bus_rdata, go to DONE.
- DONE
  - Assert the owner's done pulse unless discard is set.
  - Clear discard, go to IDLE.
  - No grant is made in DONE, so a still-high req from the completing requester is never re-granted.

Arbitration (IDLE only):
- MEM has priority over IF.
- If if_req and mem_req are both high and streak == STARVE_LIMIT, grant IF.
- streak increments on each MEM grant made while if_req is high.
- streak clears on any IF grant, or on a MEM grant with if_req low.
- streak saturates at STARVE_LIMIT.

Flush:
- flush_IF while owner=IF in REQ or RESP sets discard.
  - bus_req is never withdrawn before bus_ack.
  - The response is absorbed and if_done is not pulsed.
- flush_IF in DONE with owner=IF suppresses if_done.
- flush_IF in IDLE has no effect.
- flush_IF never affects a MEM-owned transaction.

Other rules:
- bus_rvalid outside RESP is ignored.
- bus_ack outside REQ is ignored.
- The bus_* request fields come straight from registers.
- if_rdata and mem_rdata hold their last captured value between pulses.

## Timing
Reset:
- state=IDLE; streak=0; discard=0.
- All outputs 0, including the stall signals while reset is high.
- Reset mid-transaction drops bus_req on the next edge; the memory side must tolerate an abandoned request.

Latency:
- Request sampled in cycle 0 → bus_req high in cycle 1.
- bus_ack in cycle 1 → bus_rvalid in cycle 2 at the earliest.
- done in cycle 3.
- Minimum 4 cycles per access, back-to-back one access per 4 cycles.

Other timing rules:
- bus_ack and bus_rvalid in the same cycle: rvalid is ignored. The memory guarantees rvalid ≥1 cycle after ack.
- The requester must change or drop its req in the cycle after done. The arbiter samples again in that cycle (IDLE).

## Structure
Shared package (mem_arb_pkg):
- State encoding: IDLE=2'd0, REQ=2'd1, RESP=2'd2, DONE=2'd3.
- Owner constants: OWN_IF=1'b0, OWN_MEM=1'b1.

Sub-module:
- arb_starve_ctr: saturating streak counter.
- Width $clog2(STARVE_LIMIT+1).
- Inputs inc, clr; output at_limit.
- Everything else stays in mem_port_arbiter.

## Test plan
- IF-only read: if_req=1, addr 0x100; ack in cycle 1, rvalid in cycle 2 with 0xDEADBEEF → if_done and if_rdata=0xDEADBEEF in cycle 3; stall_IF high in cycles 0–2.
- Simultaneous requests, STARVE_LIMIT=2, both reqs held and re-raised: grant order is MEM, MEM, IF, MEM, MEM, IF.
- Store: mem_we=1, wstrb=4'b0011, addr 0x2004, wdata 0x12345678 → bus fields match exactly; mem_done one cycle after rvalid; no IF grant in between.
- Flush in RESP (owner IF): rvalid arrives later → no if_done; next IDLE grants the new if_addr 0x200.
- Memory stalls bus_ack 5 cycles → bus_req and bus fields stable the whole time; flush_IF in REQ still results in no if_done.
- reset asserted in RESP → next cycle bus_req=0, all outputs 0, streak 0; a subsequent request completes normally.
